// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, FSM state encodings and parity helper.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam logic        IDLE_LVL  = 1'b1;
  localparam int unsigned PAR_MAX_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // p_sel=1 gives even parity (^data), p_sel=0 gives odd parity (~^data).
  // Callers zero-extend to PAR_MAX_W; zero padding does not change either result.
  function automatic logic par(input logic [PAR_MAX_W-1:0] data, input logic p_sel);
    return p_sel ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register between the valid/ready port and the frame FSM.
module uart_tx_hold #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              p_sel_i,
  input  logic              valid_i,
  input  logic              pop_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o,
  output logic              p_sel_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              p_sel_q, p_sel_d;

  // Capture on accept, release when the FSM loads the byte into its shifter.
  always_comb begin
    full_d  = full_q;
    data_d  = data_q;
    p_sel_d = p_sel_q;
    if (valid_i && !full_q) begin
      full_d  = 1'b1;
      data_d  = data_i;
      p_sel_d = p_sel_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      data_q  <= '0;
      p_sel_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      data_q  <= data_d;
      p_sel_q <= p_sel_d;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;
  assign p_sel_o = p_sel_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: frame FSM, shifter and bit counters driven by a shared baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = uart_pkg::DATA_W,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic              p_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy_q;
  logic              load;

  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              hold_p_sel;

  uart_tx_hold #(.DATA_W(DATA_W)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (tx_data),
    .p_sel_i (p_sel),
    .valid_i (tx_valid),
    .pop_i   (load),
    .ready_o (tx_ready),
    .full_o  (hold_full),
    .data_o  (hold_data),
    .p_sel_o (hold_p_sel)
  );

  // Next-state logic; every transition happens on a baud tick, registering the next bit.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    if (baud_tick) begin
      unique case (state_q)
        ST_IDLE: begin
          tx_d = IDLE_LVL;
          load = hold_full;
        end
        ST_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          if (stop_cnt_q != 1'(STOP_BITS - 1)) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            done_d = 1'b1;
            if (hold_full) begin
              load = 1'b1;
            end else begin
              tx_d    = IDLE_LVL;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          tx_d    = IDLE_LVL;
          state_d = ST_IDLE;
        end
      endcase
      // A load always launches a start bit, from IDLE or straight after the last stop bit.
      if (load) begin
        shift_d = hold_data;
        par_d   = par(PAR_MAX_W'(hold_data), hold_p_sel);
        tx_d    = 1'b0;
        state_d = ST_START;
      end
    end
  end

  // FSM, datapath and registered outputs; reset aborts any frame and idles the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= IDLE_LVL;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule
